// File: rtl/midi_parser_pkg.sv
// Shared MIDI constants, event types and the event payload struct for the parser.
package midi_parser_pkg;

  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned DATA_W     = 7;

  // Status nibbles of channel-voice messages
  localparam logic [NIBBLE_W-1:0] ST_NOTE_OFF   = 4'h8;
  localparam logic [NIBBLE_W-1:0] ST_NOTE_ON    = 4'h9;
  localparam logic [NIBBLE_W-1:0] ST_CONTROL    = 4'hB;
  localparam logic [NIBBLE_W-1:0] ST_PROGRAM    = 4'hC;
  localparam logic [NIBBLE_W-1:0] ST_CHAN_AT    = 4'hD;
  localparam logic [NIBBLE_W-1:0] ST_PITCH_BEND = 4'hE;

  localparam logic [BYTE_WIDTH-1:0] SYSEX_START  = 8'hF0;
  localparam logic [BYTE_WIDTH-1:0] EOX          = 8'hF7;
  localparam logic [BYTE_WIDTH-1:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [1:0] {
    EV_NOTE_OFF = 2'd0,
    EV_NOTE_ON  = 2'd1,
    EV_CONTROL  = 2'd2
  } event_type_t;

  typedef struct packed {
    event_type_t         kind;
    logic [NIBBLE_W-1:0] channel;
    logic [DATA_W-1:0]   key;
    logic [DATA_W-1:0]   value;
  } midi_event_t;

  // Program change and channel aftertouch carry a single data byte
  function automatic logic has_two_data(input logic [NIBBLE_W-1:0] nib);
    return !((nib == ST_PROGRAM) || (nib == ST_CHAN_AT));
  endfunction

endpackage

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: running status, real-time passthrough, SysEx skipping,
// channel filter and a one-entry valid/ready event register.
module midi_parser
  import midi_parser_pkg::*;
#(
  parameter bit                  OMNI    = 1'b1,
  parameter logic [NIBBLE_W-1:0] CHANNEL = 4'd0
) (
  input  logic                  clock_50_000_000,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  input  logic                  byte_valid,
  output logic                  event_valid,
  input  logic                  event_ready,
  output logic [1:0]            event_type,
  output logic [NIBBLE_W-1:0]   event_channel,
  output logic [DATA_W-1:0]     event_key,
  output logic [DATA_W-1:0]     event_value,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE, SYSEX, WAIT_D1, WAIT_D2} state_t;

  state_t                state;
  logic [BYTE_WIDTH-1:0] status_q;
  logic [DATA_W-1:0]     d1_q;
  midi_event_t           ev_q;

  logic        is_sysex, is_common, is_status, is_data;
  logic        decodable, channel_ok, fire;
  midi_event_t new_ev;

  // Byte classifier; real-time bytes (>= REALTIME_MIN) match no class and are ignored
  always_comb begin
    is_sysex  = byte_valid && (byte_data == SYSEX_START);
    is_common = byte_valid && (byte_data > SYSEX_START) && (byte_data <= EOX);
    is_status = byte_valid && byte_data[7] && (byte_data < SYSEX_START);
    is_data   = byte_valid && !byte_data[7];
  end

  // Event decode for the message completed by the current data byte
  always_comb begin
    new_ev         = '0;
    new_ev.kind    = EV_NOTE_OFF;
    new_ev.channel = status_q[3:0];
    new_ev.key     = d1_q;
    new_ev.value   = byte_data[6:0];
    decodable      = 1'b0;
    case (status_q[7:4])
      ST_NOTE_OFF: decodable = 1'b1;
      ST_NOTE_ON: begin
        decodable   = 1'b1;
        new_ev.kind = (byte_data[6:0] != 7'd0) ? EV_NOTE_ON : EV_NOTE_OFF;
      end
      ST_CONTROL: begin
        decodable   = 1'b1;
        new_ev.kind = EV_CONTROL;
      end
      ST_PITCH_BEND: decodable = 1'b0;
      default:       decodable = 1'b0;
    endcase
    channel_ok = OMNI || (status_q[3:0] == CHANNEL);
    fire       = is_data && (state == WAIT_D2) && decodable && channel_ok;
  end

  // Parse FSM and output register
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state       <= IDLE;
      status_q    <= '0;
      d1_q        <= '0;
      ev_q        <= '0;
      event_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (event_valid && event_ready) event_valid <= 1'b0;

      if (is_sysex) begin
        state <= SYSEX;
      end else if (is_common) begin
        state <= IDLE;
      end else if (is_status) begin
        status_q <= byte_data;
        state    <= WAIT_D1;
      end else if (is_data) begin
        case (state)
          WAIT_D1: begin
            d1_q <= byte_data[6:0];
            if (has_two_data(status_q[7:4])) state <= WAIT_D2;
          end
          WAIT_D2: state <= WAIT_D1;
          default: state <= state;
        endcase
      end

      if (fire) begin
        if (!event_valid || event_ready) begin
          ev_q        <= new_ev;
          event_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign event_type    = ev_q.kind;
  assign event_channel = ev_q.channel;
  assign event_key     = ev_q.key;
  assign event_value   = ev_q.value;

endmodule

// File: tb/tb_midi_parser.sv
// Bench for midi_parser: table-driven byte vectors on an OMNI and a channel-2 instance,
// plus hand sequences for back-pressure, overrun and reset mid-message.
module tb_midi_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] byte_data;
  logic       bv_a, bv_b, ready_a, ready_b;

  logic       ev_a, ov_a, ev_b, ov_b;
  logic [1:0] ty_a, ty_b;
  logic [3:0] ch_a, ch_b;
  logic [6:0] key_a, key_b, val_a, val_b;

  int total = 0;
  int passed = 0;

  always #10 clk = ~clk;

  midi_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) dut_a (
    .clock_50_000_000(clk), .reset(reset), .byte_data(byte_data), .byte_valid(bv_a),
    .event_valid(ev_a), .event_ready(ready_a), .event_type(ty_a), .event_channel(ch_a),
    .event_key(key_a), .event_value(val_a), .overrun(ov_a));

  midi_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) dut_b (
    .clock_50_000_000(clk), .reset(reset), .byte_data(byte_data), .byte_valid(bv_b),
    .event_valid(ev_b), .event_ready(ready_b), .event_type(ty_b), .event_channel(ch_b),
    .event_key(key_b), .event_value(val_b), .overrun(ov_b));

  typedef struct {
    logic        sel;
    logic [7:0]  b;
    logic        ev;
    logic [19:0] fields;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] mk(input logic [1:0] t, input int ch, input int k, input int v);
    return {t, 4'(ch), 7'(k), 7'(v)};
  endfunction

  function automatic logic [19:0] fields_of(input logic sel);
    return sel ? {ty_b, ch_b, key_b, val_b} : {ty_a, ch_a, key_a, val_a};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Strobe one byte; returns at the falling edge after the capturing edge
  task automatic send(input logic sel, input logic [7:0] b);
    @(negedge clk);
    byte_data = b;
    if (sel) bv_b = 1'b1; else bv_a = 1'b1;
    @(negedge clk);
    bv_a = 1'b0;
    bv_b = 1'b0;
  endtask

  task automatic add(input logic sel, input logic [7:0] b, input logic ev, input logic [19:0] f);
    vec_t v;
    v.sel = sel; v.b = b; v.ev = ev; v.fields = f;
    vecs.push_back(v);
  endtask

  task automatic add_none(input logic sel, input logic [7:0] b);
    add(sel, b, 1'b0, 20'd0);
  endtask

  initial begin
    reset = 1'b1; byte_data = 8'h00; bv_a = 1'b0; bv_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;

    // OMNI instance: note on, running-status note-off, real-time interleave
    add_none(0, 8'h90); add_none(0, 8'h3C); add(0, 8'h64, 1, mk(2'd1, 0, 60, 100));
    add_none(0, 8'h40); add(0, 8'h00, 1, mk(2'd0, 0, 64, 0));
    add_none(0, 8'h80); add_none(0, 8'hF8); add_none(0, 8'h3C); add_none(0, 8'hFE);
    add(0, 8'h40, 1, mk(2'd0, 0, 60, 64));
    // SysEx, orphan data after EOX, then control change
    add_none(0, 8'hF0); add_none(0, 8'h7E); add_none(0, 8'h01); add_none(0, 8'hF7);
    add_none(0, 8'h3C); add_none(0, 8'h40);
    add_none(0, 8'hB3); add_none(0, 8'h07); add(0, 8'h7F, 1, mk(2'd2, 3, 7, 127));
    // Pitch bend and running program change produce nothing
    add_none(0, 8'hE0); add_none(0, 8'h01); add_none(0, 8'h02);
    add_none(0, 8'hC5); add_none(0, 8'h05); add_none(0, 8'h3C); add_none(0, 8'h40);
    // Status byte mid-message restarts; status byte inside SysEx exits it
    add_none(0, 8'h90); add_none(0, 8'h3C); add_none(0, 8'h91); add_none(0, 8'h3C);
    add(0, 8'h50, 1, mk(2'd1, 1, 60, 80));
    add_none(0, 8'hF0); add_none(0, 8'h01); add_none(0, 8'h92); add_none(0, 8'h30);
    add(0, 8'h31, 1, mk(2'd1, 2, 48, 49));
    // Channel-2 instance: orphan data, filtered channel, accepted channel
    add_none(1, 8'h3C);
    add_none(1, 8'h91); add_none(1, 8'h3C); add_none(1, 8'h64);
    add_none(1, 8'h92); add_none(1, 8'h3C); add(1, 8'h64, 1, mk(2'd1, 2, 60, 100));
    add_none(1, 8'hC0); add_none(1, 8'h05); add_none(1, 8'h3C); add_none(1, 8'h40);
    add_none(1, 8'hB2); add_none(1, 8'h01); add(1, 8'h02, 1, mk(2'd2, 2, 1, 2));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_a", {ev_a, ov_a, fields_of(0)}, 32'd0);
    check("reset_b", {ev_b, ov_b, fields_of(1)}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].sel, vecs[i].b);
      if (vecs[i].sel) check($sformatf("vec%0d_valid", i), {ev_b, ov_b}, {vecs[i].ev, 1'b0});
      else             check($sformatf("vec%0d_valid", i), {ev_a, ov_a}, {vecs[i].ev, 1'b0});
      if (vecs[i].ev) check($sformatf("vec%0d_fields", i), fields_of(vecs[i].sel), vecs[i].fields);
      @(negedge clk);
    end

    // Back-pressure: first event held, second dropped with a single overrun pulse
    ready_a = 1'b0;
    send(0, 8'h90); send(0, 8'h3C); send(0, 8'h64);
    check("bp_first", {ev_a, ov_a, fields_of(0)}, {2'b10, mk(2'd1, 0, 60, 100)});
    send(0, 8'h3D);
    check("bp_hold", {ev_a, ov_a, fields_of(0)}, {2'b10, mk(2'd1, 0, 60, 100)});
    send(0, 8'h65);
    check("bp_overrun", {ev_a, ov_a, fields_of(0)}, {2'b11, mk(2'd1, 0, 60, 100)});
    @(negedge clk);
    check("bp_overrun_end", {ev_a, ov_a, fields_of(0)}, {2'b10, mk(2'd1, 0, 60, 100)});

    // Completion coinciding with a handshake replaces the held event
    send(0, 8'h3E);
    @(negedge clk);
    byte_data = 8'h66; bv_a = 1'b1; ready_a = 1'b1;
    @(negedge clk);
    bv_a = 1'b0; ready_a = 1'b0;
    check("swap", {ev_a, ov_a, fields_of(0)}, {2'b10, mk(2'd1, 0, 62, 102)});
    @(negedge clk);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    check("consume_hold", {ev_a, ov_a, fields_of(0)}, {2'b00, mk(2'd1, 0, 62, 102)});

    // Reset between the data bytes discards the partial message and running status
    ready_a = 1'b1;
    send(0, 8'h90); send(0, 8'h3C);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    send(0, 8'h64);
    check("rst_mid", {ev_a, ov_a, fields_of(0)}, 32'd0);
    send(0, 8'h3C); send(0, 8'h40);
    check("rst_orphan", {ev_a, ov_a}, 32'd0);
    send(0, 8'h90); send(0, 8'h3C); send(0, 8'h64);
    check("rst_recover", {ev_a, ov_a, fields_of(0)}, {2'b10, mk(2'd1, 0, 60, 100)});
    @(negedge clk);
    check("rst_recover_consumed", {ev_a, ov_a}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
